// File: rtl/light_monitor_if.sv
// Lamp observation and fault-report bundle between the intersection controller
// side and the safety monitor.
interface light_monitor_if;
    logic [2:0]  lightA;
    logic [2:0]  lightB;
    logic        clr_fault;
    logic        fault;
    logic [2:0]  fault_code;
    logic        fault_dir;
    logic [15:0] cycles_done;

    modport master (
        output lightA, lightB, clr_fault,
        input  fault, fault_code, fault_dir, cycles_done
    );

    modport slave (
        input  lightA, lightB, clr_fault,
        output fault, fault_code, fault_dir, cycles_done
    );
endinterface

// File: rtl/light_monitor.sv
// Safety monitor for a two-approach signal controller: checks lamp encoding,
// conflicts, phase order, yellow timing and stuck lamps; latches the first fault.
module light_monitor #(
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 4,
    parameter int MAX_HOLD   = 15,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    light_monitor_if.slave bus
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] MIN_Y_L = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W:0]   MAX_Y_L = (CNT_W+1)'(MAX_YELLOW);
    localparam logic [CNT_W:0]   MAX_H_L = (CNT_W+1)'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       prev_a, prev_b;
    logic [CNT_W-1:0] dwell_a, dwell_b;
    logic             fault_r;
    logic [2:0]       code_r;
    logic             dir_r;
    logic [15:0]      cycles_r;

    logic [5:0]       hit_a, hit_b;
    logic             det;
    logic [2:0]       det_code;
    logic             det_dir;

    function automatic logic is_lamp(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        return (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
        return (&d) ? d : d + 1'b1;
    endfunction

    // Bit i flags fault code i+1 for one approach; the conflict bit is filled in jointly.
    function automatic logic [5:0] lamp_faults(input logic [2:0] c, input logic [2:0] p,
                                               input logic [CNT_W-1:0] d, input logic run);
        logic [5:0]     f;
        logic [CNT_W:0] nxt;
        nxt  = {1'b0, d} + 1'b1;
        f    = '0;
        f[0] = !is_lamp(c);
        if (run) begin
            f[2] = (c != p) && !legal_step(p, c);
            f[3] = (p == YEL) && (c == RED) && (d < MIN_Y_L);
            f[4] = (p == YEL) && (c == YEL) && (nxt > MAX_Y_L);
            f[5] = (c == p) && (nxt > MAX_H_L);
        end
        return f;
    endfunction

    always_comb begin
        hit_a    = lamp_faults(bus.lightA, prev_a, dwell_a, state == S_RUN);
        hit_b    = lamp_faults(bus.lightB, prev_b, dwell_b, state == S_RUN);
        hit_a[1] = !bus.lightA[2] && !bus.lightB[2];
        if (state == S_FAULT) begin
            hit_a = '0;
            hit_b = '0;
        end
        det      = |{hit_a, hit_b};
        det_code = '0;
        det_dir  = 1'b0;
        // Scan from the highest code down so the lowest code, and A on a tie, wins.
        for (int i = 5; i >= 0; i--) begin
            if (hit_a[i] || hit_b[i]) begin
                det_code = 3'(i + 1);
                det_dir  = !hit_a[i];
            end
        end

        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = det ? S_FAULT : S_RUN;
            S_RUN:   if (det) state_nxt = S_FAULT;
            S_FAULT: if (bus.clr_fault) state_nxt = S_INIT;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_a   <= '0;
            prev_b   <= '0;
            dwell_a  <= '0;
            dwell_b  <= '0;
            fault_r  <= 1'b0;
            code_r   <= '0;
            dir_r    <= 1'b0;
            cycles_r <= '0;
        end else begin
            case (state)
                S_INIT, S_RUN: begin
                    prev_a  <= bus.lightA;
                    prev_b  <= bus.lightB;
                    dwell_a <= (state == S_RUN && bus.lightA == prev_a) ? sat_inc(dwell_a) : CNT_W'(1);
                    dwell_b <= (state == S_RUN && bus.lightB == prev_b) ? sat_inc(dwell_b) : CNT_W'(1);
                    if (det) begin
                        fault_r <= 1'b1;
                        code_r  <= det_code;
                        dir_r   <= det_dir;
                    end else if (state == S_RUN && prev_a == RED && bus.lightA == GRN) begin
                        cycles_r <= cycles_r + 16'd1;
                    end
                end
                S_FAULT: begin
                    if (bus.clr_fault) begin
                        fault_r <= 1'b0;
                        code_r  <= '0;
                        dir_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fault       = fault_r;
    assign bus.fault_code  = code_r;
    assign bus.fault_dir   = dir_r;
    assign bus.cycles_done = cycles_r;
endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: directed fault scenarios plus randomized lamp
// disturbance, all compared against a rule-level reference model.
module tb_light_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    light_monitor_if bus ();

    light_monitor #(
        .MIN_YELLOW(2),
        .MAX_YELLOW(4),
        .MAX_HOLD  (15),
        .CNT_W     (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int ph    = 0;

    // Reference model: mode 0 = capturing, 1 = monitoring, 2 = fault latched.
    int         m_mode;
    int         m_da, m_db;
    logic [2:0] m_pa, m_pb;
    logic       m_fault;
    int         m_code;
    logic       m_dir;
    int         m_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] sched_a(input int p);
        int t;
        t = p % 24;
        if (t < 8)  return G;
        if (t < 11) return Y;
        return R;
    endfunction

    function automatic logic [2:0] sched_b(input int p);
        int t;
        t = p % 24;
        if (t < 11) return R;
        if (t < 21) return G;
        return Y;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] l);
        if (l == G) return Y;
        if (l == Y) return R;
        return G;
    endfunction

    function automatic bit is_lamp(input logic [2:0] l);
        return (l == R) || (l == Y) || (l == G);
    endfunction

    function automatic int lamp_code(input logic [2:0] c, input logic [2:0] p, input int d);
        if (c != p && c != succ(p))     return 3;
        if (p == Y && c == R && d < 2)  return 4;
        if (p == Y && c == Y && d >= 4) return 5;
        if (c == p && d >= 15)          return 6;
        return 7;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_da = 0; m_db = 0; m_pa = 3'b000; m_pb = 3'b000;
        m_fault = 1'b0; m_code = 0; m_dir = 1'b0; m_cyc = 0;
    endtask

    task automatic model_step(input logic [2:0] a, input logic [2:0] b, input logic clr);
        int ca, cb;
        bit was_run;
        if (m_mode == 2) begin
            if (clr) begin
                m_fault = 1'b0; m_code = 0; m_dir = 1'b0; m_mode = 0;
            end
            return;
        end
        was_run = (m_mode == 1);
        ca = is_lamp(a) ? 7 : 1;
        cb = is_lamp(b) ? 7 : 1;
        if (!a[2] && !b[2] && ca > 2) ca = 2;
        if (was_run) begin
            if (lamp_code(a, m_pa, m_da) < ca) ca = lamp_code(a, m_pa, m_da);
            if (lamp_code(b, m_pb, m_db) < cb) cb = lamp_code(b, m_pb, m_db);
        end
        if (ca != 7 || cb != 7) begin
            m_fault = 1'b1;
            m_code  = (ca <= cb) ? ca : cb;
            m_dir   = (ca <= cb) ? 1'b0 : 1'b1;
            m_mode  = 2;
        end else begin
            if (was_run && m_pa == R && a == G) m_cyc = (m_cyc + 1) % 65536;
            m_mode = 1;
        end
        m_da = (was_run && a == m_pa) ? ((m_da < 255) ? m_da + 1 : 255) : 1;
        m_db = (was_run && b == m_pb) ? ((m_db < 255) ? m_db + 1 : 255) : 1;
        m_pa = a;
        m_pb = b;
    endtask

    function automatic logic [31:0] obs_vec();
        return {11'b0, bus.fault, bus.fault_code, bus.fault_dir, bus.cycles_done};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {11'b0, m_fault, 3'(m_code), m_dir, 16'(m_cyc)};
    endfunction

    function automatic logic [31:0] fault_vec();
        return {27'b0, bus.fault, bus.fault_code, bus.fault_dir};
    endfunction

    task automatic cycle(input logic [2:0] a, input logic [2:0] b, input logic clr, input string tag);
        bus.lightA    = a;
        bus.lightB    = b;
        bus.clr_fault = clr;
        @(posedge clk);
        model_step(a, b, clr);
        #1;
        chk(tag, obs_vec(), exp_vec());
        bus.clr_fault = 1'b0;
    endtask

    task automatic run_nom(input int n);
        repeat (n) begin
            cycle(sched_a(ph), sched_b(ph), 1'b0, "nominal");
            ph++;
        end
    endtask

    task automatic go_phase(input int t);
        run_nom(2);
        while (ph % 24 != t) run_nom(1);
    endtask

    // Clear so that the recapture lands on phase 0 of the schedule.
    task automatic clear();
        while (ph % 24 != 23) run_nom(1);
        cycle(sched_a(ph), sched_b(ph), 1'b1, "clear");
        ph++;
        chk("clear_fault", {31'b0, bus.fault}, 32'd0);
    endtask

    initial begin
        logic [2:0] a, b;
        logic       clr;
        model_reset();
        bus.lightA    = G;
        bus.lightB    = R;
        bus.clr_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs_vec(), 32'd0);
        rst = 1'b0;

        run_nom(2400);
        chk("nominal_cycles", {16'b0, bus.cycles_done}, 32'd99);

        cycle(3'b011, sched_b(ph), 1'b0, "enc");
        chk("enc_code", fault_vec(), {27'b0, 1'b1, 3'd1, 1'b0});
        run_nom(20);
        chk("enc_held", fault_vec(), {27'b0, 1'b1, 3'd1, 1'b0});
        clear();

        run_nom(5);
        cycle(G, G, 1'b0, "conflict");
        chk("conflict_code", fault_vec(), {27'b0, 1'b1, 3'd2, 1'b0});
        clear();
        run_nom(30);
        chk("post_clear_clean", fault_vec(), 32'd0);
        clear();

        go_phase(13);
        cycle(R, R, 1'b0, "seq_b");
        chk("seq_code", fault_vec(), {27'b0, 1'b1, 3'd3, 1'b1});
        clear();

        go_phase(8);
        run_nom(1);
        cycle(R, R, 1'b0, "short_y");
        chk("short_yellow", fault_vec(), {27'b0, 1'b1, 3'd4, 1'b0});
        clear();

        go_phase(8);
        repeat (4) cycle(Y, R, 1'b0, "long_y");
        chk("long_y_ok4", fault_vec(), 32'd0);
        cycle(Y, R, 1'b0, "long_y");
        chk("long_yellow", fault_vec(), {27'b0, 1'b1, 3'd5, 1'b0});
        clear();

        repeat (15) cycle(G, R, 1'b0, "stuck");
        chk("stuck_ok15", fault_vec(), 32'd0);
        cycle(G, R, 1'b0, "stuck");
        chk("stuck_code", fault_vec(), {27'b0, 1'b1, 3'd6, 1'b0});

        #2 rst = 1'b1;
        #1;
        chk("async_rst", obs_vec(), 32'd0);
        model_reset();
        ph = 0;
        @(negedge clk);
        rst = 1'b0;

        run_nom(3);
        cycle(3'b000, G, 1'b0, "prio");
        chk("prio_enc", fault_vec(), {27'b0, 1'b1, 3'd1, 1'b0});
        clear();

        go_phase(5);
        force dut.cycles_r = 16'hFFFF;
        #1;
        release dut.cycles_r;
        m_cyc = 16'hFFFF;
        chk("preload", {16'b0, bus.cycles_done}, 32'h0000FFFF);
        go_phase(0);
        run_nom(1);
        chk("wrap", {16'b0, bus.cycles_done}, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            a   = sched_a(ph);
            b   = sched_b(ph);
            if ($urandom_range(0, 39) == 0) a = 3'($urandom);
            if ($urandom_range(0, 39) == 0) b = 3'($urandom);
            clr = ($urandom_range(0, 5) == 0);
            cycle(a, b, clr, "random");
            if ($urandom_range(0, 29) != 0) ph++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/light_monitor.md
Name: light_monitor

Overview:
- Safety monitor placed directly downstream of the two-way intersection controller.
- Watches its 3-bit lamp outputs for both approaches (A and B) every cycle.
- Flags illegal encodings, conflicting greens, out-of-order phase changes, bad yellow timing and stuck lamps.
- Latches the first fault with a code until software clears it, and counts completed A-approach cycles for health telemetry.

Parameters:
- MIN_YELLOW, 2: minimum legal yellow dwell in cycles.
- MAX_YELLOW, 4: maximum legal yellow dwell in cycles.
- MAX_HOLD, 15: maximum dwell of any single lamp in cycles (watchdog).
- CNT_W, 8: width of the per-approach dwell counters; saturating.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- lightA  in  3  approach A lamps {Red, Yellow, Green}; bit2=R, bit1=Y, bit0=G.
- lightB  in  3  approach B lamps, same encoding.
- clr_fault  in  1  single-cycle pulse; clears the latched fault.
- fault  out  1  latched fault flag.
- fault_code  out  3  0=none, 1=ILLEGAL_ENC, 2=CONFLICT, 3=BAD_SEQ, 4=SHORT_YELLOW, 5=LONG_YELLOW, 6=STUCK.
- fault_dir  out  1  approach that caused the fault: 0=A, 1=B; 0 for codes 1 and 2 when both approaches are involved.
- cycles_done  out  16  count of completed A cycles; wraps.

Behaviour:
- Reset (rst high, async): state=INIT; fault=0, fault_code=0, fault_dir=0, cycles_done=0; prevA/prevB=0; dwell counters=0.
- State INIT: on the next clk, capture lightA/lightB into prevA/prevB and set both dwell counters to 1.
  - Only the encoding check (1) and the conflict check (2) run in INIT.
  - Move to RUN if clean, otherwise to FAULT.
- State RUN: each clk, evaluate the current inputs against prevA/prevB and the dwell counters. For each approach X in {A, B}:
  - Encoding: lightX not exactly one-hot -> code 1.
  - Conflict: neither approach Red (lightA[2]=0 and lightB[2]=0) -> code 2.
  - Sequence: legal changes are G->Y, Y->R and R->G only; holding the same lamp is legal; any other change -> code 3.
  - Short yellow: on a Y->R change with dwellX < MIN_YELLOW -> code 4.
  - Long yellow: lightX still Y and dwellX+1 > MAX_YELLOW -> code 5.
  - Stuck: lightX unchanged and dwellX+1 > MAX_HOLD -> code 6.
  - Dwell update: lamp changed -> dwellX=1; lamp unchanged -> dwellX+1, saturating at 2^CNT_W-1.
  - prevX <= lightX.
- Multiple simultaneous faults: lowest code number wins. For the same code on both approaches, A wins (fault_dir=0).
- Any fault detected -> next state FAULT. fault, fault_code and fault_dir are registered on the same edge, so fault is visible one cycle after the offending input is presented.
- State FAULT:
  - All checks suspended; fault, code and dir held; cycles_done frozen.
  - clr_fault=1 -> fault=0, code=0, dir=0, next state INIT (re-capture).
- clr_fault outside FAULT: ignored.
- clr_fault in the same cycle as a newly detected fault in RUN: the fault wins and is latched.
- cycles_done: +1 in RUN on an A change R->G, only when no fault is detected that cycle. Wraps 0xFFFF->0x0000.
- Reset mid-operation: immediate return to reset values regardless of state; no fault is preserved.
- Upstream reset pattern (A=G, B=R) is legal; the monitor's first INIT sample may be that pattern.
- Parameter legality: 1 <= MIN_YELLOW <= MAX_YELLOW < MAX_HOLD < 2^CNT_W. Outside that range is unsupported.

Test Plan:
- Nominal run: A G8/Y3/R13 and B R11/G10/Y3 (24-cycle period), for 100 periods -> fault stays 0; cycles_done=99 or 100 depending on start phase; no code ever set.
- Illegal encoding: in RUN force lightA=3'b011 for one cycle -> next cycle fault=1, fault_code=1, fault_dir=0; code held for 20 cycles while inputs return to normal.
- Conflict: force A=G and B=G together -> fault_code=2. Then pulse clr_fault -> fault=0 next cycle, state INIT. Clean input afterwards -> no new fault.
- Sequence and yellow timing:
  - B changes G->R directly -> code 3, dir=1.
  - After clear, A yellow for 1 cycle then R -> code 4, dir=0.
  - After clear, A yellow for 5 cycles -> code 5 raised on the 5th yellow cycle.
- Stuck lamp: hold A=G, B=R for 16 cycles after INIT -> code 6, dir=0 (A beats B on the tie). Assert rst mid-FAULT -> all outputs 0 asynchronously.
- Priority and wrap:
  - A=3'b000 with B=G in the same cycle -> code 1 (not 2).
  - Preload cycles_done=0xFFFF via a long run (or force), then one more A R->G -> 0x0000.
